mem_stage: RTL and testbench
============================

# mem_stage

MEM stage of the five-stage MIPS pipeline, directly downstream of EX. Contains the EX/MEM pipeline register, the byte-addressable data memory, store-data forwarding from W, and load alignment and extension. It also drives the M-stage values (`ALUout_M`, `PC8_M_out`) that EX uses as forwarding sources.

## Interface
- `DM_WORDS`, default 1024: data-memory depth in 32-bit words. Power of two; address index is `log2(DM_WORDS)` bits taken from addr[2 +: n].
- `clk` input 1: single pipeline clock; all state changes on the rising edge.
- `reset_n` input 1: asynchronous, active-low reset.
- `Instr_E_in` input 32: instruction leaving EX.
- `ALUout_E` input 32: EX result, the effective address for loads and stores.
- `RT_E_in` input 32: forwarded rt value from EX, the store data.
- `A3_E_in` input 5: destination register number.
- `PC4_E_in`, `PC8_E_in` input 32 each: PC+4 and PC+8 of the instruction.
- `WD_W` input 32: write-back data from W.
- `ForwardRTM` input 1: select `WD_W` instead of the registered rt as store data. Driven by the hazard unit.
- `Instr_M_out` output 32: registered instruction.
- `ALUout_M` output 32: registered ALU result.
- `A3_M_out` output 5: registered destination.
- `PC4_M_out`, `PC8_M_out` output 32 each: registered PCs.
- `DMout_M` output 32: load result after alignment and extension. Combinational from M-stage state.
- `AdE_M` output 1: address error (misaligned or out of range) for the load/store currently in M.

## Operation
- EX/MEM register captures Instr, ALUout, RT, A3, PC4 and PC8 every rising edge. No stall and no flush: MEM never stalls.
- Store data = `ForwardRTM ? WD_W : RT_M`, where `RT_M` is the registered rt.
- Decode uses opcode bits [31:26] of `Instr_M_out`:
  - loads: lw 0x23, lh 0x21, lhu 0x25, lb 0x20, lbu 0x24
  - stores: sw 0x2B, sh 0x29, sb 0x28
  - all other opcodes: no memory access, `DMout_M`=0, `AdE_M`=0.
- Address a = `ALUout_M`.
- Misaligned access: word access with a[1:0]≠0, or halfword access with a[0]≠0.
- Out-of-range access: a ≥ 4·`DM_WORDS`.
- On either error: `AdE_M`=1, store suppressed (no byte written), `DMout_M`=0.
- Store byte enables (byte lane k = bits [8k+7:8k]):
  - sw writes all four lanes.
  - sh writes lanes {1,0} if a[1]=0, else lanes {3,2}, with data[15:0] replicated into both halves.
  - sb writes lane a[1:0], with data[7:0] replicated into all lanes.
- Memory read is combinational on the word at index a[2 +: n]. Lane selection uses a[1:0]:
  - lb and lh sign-extend.
  - lbu and lhu zero-extend.
  - lw passes the word through.
- Memory write happens on the rising edge, while the store occupies M.

## Timing
- Reset (`reset_n`=0, asynchronous): all pipeline registers clear to 0 (Instr 0 = sll $0, a nop), every memory word clears to 0, all outputs are 0. Operation resumes on the first rising edge after `reset_n` deasserts.
- Reset asserted mid-store: no partial write. Memory holds 0 after reset.
- Latency from EX to M outputs: 1 cycle. `DMout_M` is valid in the same cycle the load is in M.
- Store in cycle t, load from the same word in cycle t+1: the load returns the new data, because the write committed at the t→t+1 edge.
- `WD_W` forwarding is used in the same cycle with no extra delay.

## Structure
- Shared package `mips_defs` holds the opcode constants and the access-size enum (`BYTE`, `HALF`, `WORD`). The same constants are reused by `ctrl`.
- One sub-module `dm_bank`:
  - `DM_WORDS`×32 array with 4-bit byte-enable synchronous write.
  - combinational read.
  - asynchronous active-low clear.
- `mem_stage` keeps decode, lane steering, extension and error checks.

## Test plan
- Reset: drive garbage inputs with `reset_n`=0 → all outputs 0; lw 0x0 after release returns 0.
- sw 0x12345678 @0x10, then lw @0x10 next cycle → `DMout_M`=0x12345678; `ALUout_M`=0x10 one cycle after EX.
- Sub-word access, memory word @0x10 = 0x12345678:
  - sb 0x80 @0x11 → lw @0x10 returns 0x12348078.
  - lb @0x11 → 0xFFFFFF80; lbu @0x11 → 0x00000080.
  - sh 0xBEEF @0x12, then lh @0x12 → 0xFFFFBEEF; lhu @0x12 → 0x0000BEEF.
- Forwarding: sw with `RT_E_in`=0x1, `ForwardRTM`=1 and `WD_W`=0xCAFEF00D → memory receives 0xCAFEF00D.
- Errors:
  - sw @0x2 → `AdE_M`=1, memory unchanged.
  - lh @0x3 → `AdE_M`=1, `DMout_M`=0.
  - sw @4·`DM_WORDS` → `AdE_M`=1, no write.
- Reset mid-operation: pulse `reset_n` low between a sw and the following lw → lw returns 0 and the outputs are 0 during the pulse.

Source files
------------

// File: rtl/mips_defs.sv
// rtl/mips_defs.sv - shared MIPS opcode constants and memory-access decode
package mips_defs;

  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_SW  = 6'h2B;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SB  = 6'h28;

  typedef enum logic [1:0] {BYTE, HALF, WORD} acc_size_e;

  typedef struct packed {
    logic      load;
    logic      store;
    logic      sign;
    acc_size_e size;
  } mem_op_t;

  function automatic mem_op_t decode_mem_op(input logic [5:0] op);
    mem_op_t m;
    m = '{load: 1'b0, store: 1'b0, sign: 1'b0, size: WORD};
    case (op)
      OP_LW:   m = '{load: 1'b1, store: 1'b0, sign: 1'b0, size: WORD};
      OP_LH:   m = '{load: 1'b1, store: 1'b0, sign: 1'b1, size: HALF};
      OP_LHU:  m = '{load: 1'b1, store: 1'b0, sign: 1'b0, size: HALF};
      OP_LB:   m = '{load: 1'b1, store: 1'b0, sign: 1'b1, size: BYTE};
      OP_LBU:  m = '{load: 1'b1, store: 1'b0, sign: 1'b0, size: BYTE};
      OP_SW:   m = '{load: 1'b0, store: 1'b1, sign: 1'b0, size: WORD};
      OP_SH:   m = '{load: 1'b0, store: 1'b1, sign: 1'b0, size: HALF};
      OP_SB:   m = '{load: 1'b0, store: 1'b1, sign: 1'b0, size: BYTE};
      default: m = '{load: 1'b0, store: 1'b0, sign: 1'b0, size: WORD};
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - EX-to-MEM bus and M-stage result signals
interface mem_stage_if;
  logic [31:0] Instr_E_in;
  logic [31:0] ALUout_E;
  logic [31:0] RT_E_in;
  logic [4:0]  A3_E_in;
  logic [31:0] PC4_E_in;
  logic [31:0] PC8_E_in;
  logic [31:0] WD_W;
  logic        ForwardRTM;

  logic [31:0] Instr_M_out;
  logic [31:0] ALUout_M;
  logic [4:0]  A3_M_out;
  logic [31:0] PC4_M_out;
  logic [31:0] PC8_M_out;
  logic [31:0] DMout_M;
  logic        AdE_M;

  modport master (
    output Instr_E_in, ALUout_E, RT_E_in, A3_E_in, PC4_E_in, PC8_E_in, WD_W, ForwardRTM,
    input  Instr_M_out, ALUout_M, A3_M_out, PC4_M_out, PC8_M_out, DMout_M, AdE_M
  );

  modport slave (
    input  Instr_E_in, ALUout_E, RT_E_in, A3_E_in, PC4_E_in, PC8_E_in, WD_W, ForwardRTM,
    output Instr_M_out, ALUout_M, A3_M_out, PC4_M_out, PC8_M_out, DMout_M, AdE_M
  );
endinterface

// File: rtl/mem_stage_dm_bank.sv
// rtl/mem_stage_dm_bank.sv - data memory: byte-enable sync write, comb read, async clear
module dm_bank #(
  parameter int DM_WORDS = 1024,
  localparam int AW = $clog2(DM_WORDS)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [3:0]    we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem_q [DM_WORDS];

  // Reset wipes the whole array so a store caught by reset never lands.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DM_WORDS; i++) mem_q[i] <= '0;
    end else begin
      for (int k = 0; k < 4; k++)
        if (we_i[k]) mem_q[addr_i][8*k +: 8] <= wdata_i[8*k +: 8];
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MIPS MEM stage: EX/MEM register, data memory, store forwarding, load extend
module mem_stage
  import mips_defs::*;
#(
  parameter int DM_WORDS = 1024
) (
  input logic        clk,
  input logic        reset_n,
  mem_stage_if.slave bus
);

  localparam int AW = $clog2(DM_WORDS);

  logic [31:0] instr_q, aluout_q, rt_q, pc4_q, pc8_q;
  logic [4:0]  a3_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      instr_q  <= '0;
      aluout_q <= '0;
      rt_q     <= '0;
      a3_q     <= '0;
      pc4_q    <= '0;
      pc8_q    <= '0;
    end else begin
      instr_q  <= bus.Instr_E_in;
      aluout_q <= bus.ALUout_E;
      rt_q     <= bus.RT_E_in;
      a3_q     <= bus.A3_E_in;
      pc4_q    <= bus.PC4_E_in;
      pc8_q    <= bus.PC8_E_in;
    end
  end

  mem_op_t     op_m;
  logic [31:0] addr, store_data, wdata, rdata, load_val;
  logic [3:0]  be, we;
  logic        misaligned, out_of_range, ade;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign op_m         = decode_mem_op(instr_q[31:26]);
  assign addr         = aluout_q;
  assign out_of_range = |addr[31:AW+2];
  assign misaligned   = ((op_m.size == WORD) && (addr[1:0] != 2'b00)) ||
                        ((op_m.size == HALF) && addr[0]);
  assign ade          = (op_m.load || op_m.store) && (misaligned || out_of_range);
  assign store_data   = bus.ForwardRTM ? bus.WD_W : rt_q;

  always_comb begin
    be    = 4'b0000;
    wdata = store_data;
    case (op_m.size)
      BYTE: begin
        be    = 4'b0001 << addr[1:0];
        wdata = {4{store_data[7:0]}};
      end
      HALF: begin
        be    = addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{store_data[15:0]}};
      end
      default: be = 4'b1111;
    endcase
  end

  assign we = (op_m.store && !ade) ? be : 4'b0000;

  dm_bank #(.DM_WORDS(DM_WORDS)) u_dm (
    .clk     (clk),
    .reset_n (reset_n),
    .we_i    (we),
    .addr_i  (addr[2 +: AW]),
    .wdata_i (wdata),
    .rdata_o (rdata)
  );

  always_comb begin
    case (addr[1:0])
      2'd1:    rbyte = rdata[15:8];
      2'd2:    rbyte = rdata[23:16];
      2'd3:    rbyte = rdata[31:24];
      default: rbyte = rdata[7:0];
    endcase
    rhalf    = addr[1] ? rdata[31:16] : rdata[15:0];
    load_val = '0;
    if (op_m.load && !ade) begin
      case (op_m.size)
        BYTE:    load_val = op_m.sign ? {{24{rbyte[7]}}, rbyte} : {24'b0, rbyte};
        HALF:    load_val = op_m.sign ? {{16{rhalf[15]}}, rhalf} : {16'b0, rhalf};
        default: load_val = rdata;
      endcase
    end
  end

  assign bus.Instr_M_out = instr_q;
  assign bus.ALUout_M    = aluout_q;
  assign bus.A3_M_out    = a3_q;
  assign bus.PC4_M_out   = pc4_q;
  assign bus.PC8_M_out   = pc8_q;
  assign bus.DMout_M     = load_val;
  assign bus.AdE_M       = ade;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - self-checking bench for mem_stage
module tb_mem_stage;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  mem_stage_if bus();

  mem_stage #(.DM_WORDS(1024)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [31:0] instr;
    logic [31:0] alu;
    logic [4:0]  a3;
    logic [31:0] pc8;
    logic [31:0] dm;
    logic        ade;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          fails = 0;
  logic [31:0] pc = 32'h0040_0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic issue(input string tag, input logic [5:0] op, input logic [31:0] addr,
                       input logic [31:0] rt, input logic fwd, input logic [31:0] wd,
                       input logic [31:0] exp_dm, input logic exp_ade);
    logic [31:0] ins;
    exp_t e;
    ins = {op, 5'd29, 5'd8, addr[15:0]};
    bus.Instr_E_in = ins;
    bus.ALUout_E   = addr;
    bus.RT_E_in    = rt;
    bus.A3_E_in    = pc[6:2];
    bus.PC4_E_in   = pc + 32'd4;
    bus.PC8_E_in   = pc + 32'd8;
    sb.push_back('{ins, addr, pc[6:2], pc + 32'd8, exp_dm, exp_ade});
    pc = pc + 32'd4;
    @(posedge clk);
    #1;
    bus.ForwardRTM = fwd;
    bus.WD_W       = wd;
    #1;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk({tag, "_instr"}, bus.Instr_M_out, e.instr);
      chk({tag, "_alu"},   bus.ALUout_M, e.alu);
      chk({tag, "_a3"},    {27'b0, bus.A3_M_out}, {27'b0, e.a3});
      chk({tag, "_pc8"},   bus.PC8_M_out, e.pc8);
      chk({tag, "_dm"},    bus.DMout_M, e.dm);
      chk({tag, "_ade"},   {31'b0, bus.AdE_M}, {31'b0, e.ade});
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_instr0"}, bus.Instr_M_out, 32'h0);
    chk({tag, "_alu0"},   bus.ALUout_M, 32'h0);
    chk({tag, "_a30"},    {27'b0, bus.A3_M_out}, 32'h0);
    chk({tag, "_pc40"},   bus.PC4_M_out, 32'h0);
    chk({tag, "_pc80"},   bus.PC8_M_out, 32'h0);
    chk({tag, "_dm0"},    bus.DMout_M, 32'h0);
    chk({tag, "_ade0"},   {31'b0, bus.AdE_M}, 32'h0);
  endtask

  task automatic reset_pulse(input string tag);
    reset_n = 1'b0;
    #1;
    chk_outputs_zero(tag);
    @(posedge clk);
    #1;
    chk_outputs_zero({tag, "_held"});
    reset_n = 1'b1;
    sb.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.Instr_E_in = 32'hFFFF_FFFF;
    bus.ALUout_E   = 32'hDEAD_BEEF;
    bus.RT_E_in    = 32'hA5A5_A5A5;
    bus.A3_E_in    = 5'h1F;
    bus.PC4_E_in   = 32'h1234_5678;
    bus.PC8_E_in   = 32'h8765_4321;
    bus.WD_W       = 32'h5A5A_5A5A;
    bus.ForwardRTM = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_outputs_zero("reset");
    bus.ForwardRTM = 1'b0;
    reset_n = 1'b1;

    issue("lw0_after_reset", mips_defs::OP_LW, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);

    issue("sw_10",  mips_defs::OP_SW, 32'h10, 32'h1234_5678, 1'b0, 32'h0, 32'h0, 1'b0);
    issue("lw_10",  mips_defs::OP_LW, 32'h10, 32'h0, 1'b0, 32'h0, 32'h1234_5678, 1'b0);
    issue("sb_11",  mips_defs::OP_SB, 32'h11, 32'h0000_0080, 1'b0, 32'h0, 32'h0, 1'b0);
    issue("lw_sb",  mips_defs::OP_LW, 32'h10, 32'h0, 1'b0, 32'h0, 32'h1234_8078, 1'b0);
    issue("lb_11",  mips_defs::OP_LB, 32'h11, 32'h0, 1'b0, 32'h0, 32'hFFFF_FF80, 1'b0);
    issue("lbu_11", mips_defs::OP_LBU, 32'h11, 32'h0, 1'b0, 32'h0, 32'h0000_0080, 1'b0);
    issue("sh_12",  mips_defs::OP_SH, 32'h12, 32'h0000_BEEF, 1'b0, 32'h0, 32'h0, 1'b0);
    issue("lh_12",  mips_defs::OP_LH, 32'h12, 32'h0, 1'b0, 32'h0, 32'hFFFF_BEEF, 1'b0);
    issue("lhu_12", mips_defs::OP_LHU, 32'h12, 32'h0, 1'b0, 32'h0, 32'h0000_BEEF, 1'b0);
    issue("lw_sh",  mips_defs::OP_LW, 32'h10, 32'h0, 1'b0, 32'h0, 32'hBEEF_8078, 1'b0);
    issue("lb_13",  mips_defs::OP_LB, 32'h13, 32'h0, 1'b0, 32'h0, 32'hFFFF_FFBE, 1'b0);
    issue("lhu_10", mips_defs::OP_LHU, 32'h10, 32'h0, 1'b0, 32'h0, 32'h0000_8078, 1'b0);

    issue("sw_fwd", mips_defs::OP_SW, 32'h14, 32'h0000_0001, 1'b1, 32'hCAFE_F00D, 32'h0, 1'b0);
    issue("lw_fwd", mips_defs::OP_LW, 32'h14, 32'h0, 1'b0, 32'h0, 32'hCAFE_F00D, 1'b0);
    issue("lb_17",  mips_defs::OP_LB, 32'h17, 32'h0, 1'b0, 32'h0, 32'hFFFF_FFCA, 1'b0);
    issue("lh_16",  mips_defs::OP_LH, 32'h16, 32'h0, 1'b0, 32'h0, 32'hFFFF_CAFE, 1'b0);
    issue("lbu_14", mips_defs::OP_LBU, 32'h14, 32'h0, 1'b0, 32'h0, 32'h0000_000D, 1'b0);

    issue("sw_mis",   mips_defs::OP_SW, 32'h2, 32'hFFFF_FFFF, 1'b0, 32'h0, 32'h0, 1'b1);
    issue("lw_0_mis", mips_defs::OP_LW, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    issue("lh_mis",   mips_defs::OP_LH, 32'h3, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
    issue("lw_mis",   mips_defs::OP_LW, 32'h12, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
    issue("sw_oor",   mips_defs::OP_SW, 32'h1000, 32'hDEAD_BEEF, 1'b0, 32'h0, 32'h0, 1'b1);
    issue("lw_0_oor", mips_defs::OP_LW, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    issue("lw_oor",   mips_defs::OP_LW, 32'h1010, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1);
    issue("lw_top",   mips_defs::OP_LW, 32'hFFC, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    issue("nonmem",   6'h09, 32'h3, 32'h1, 1'b0, 32'h0, 32'h0, 1'b0);

    issue("sw_20", mips_defs::OP_SW, 32'h20, 32'h55AA_55AA, 1'b0, 32'h0, 32'h0, 1'b0);
    reset_pulse("rst_mid_store");
    issue("lw_20", mips_defs::OP_LW, 32'h20, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);

    issue("sw_24",     mips_defs::OP_SW, 32'h24, 32'h1111_2222, 1'b0, 32'h0, 32'h0, 1'b0);
    issue("lw_24_pre", mips_defs::OP_LW, 32'h24, 32'h0, 1'b0, 32'h0, 32'h1111_2222, 1'b0);
    reset_pulse("rst_after_store");
    issue("lw_24_post", mips_defs::OP_LW, 32'h24, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);
    issue("lw_14_post", mips_defs::OP_LW, 32'h14, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
